ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
// Shares one port of the 32-bit byte-write dual-port RAM among N_REQ requesters
// (default: core load/store unit = req 0, hex loader/DMA = req 1). Round-robin
// grant, one transaction at a time. Per-requester req/ack handshake. Each request
// is latched, then driven onto the RAM port for exactly one cycle. Read data is
// registered. Misaligned stores are rejected with an error and never reach the RAM.
// PARAMETERS
// N_REQ    2   number of requesters (2..8)
// ADDR_W   15  byte address width (RAM holds 2^(ADDR_W-2) words)
// PORTS
// clk        in   1             clock; all state updates on posedge
// rst        in   1             synchronous reset, active-high
// req        in   N_REQ         request per requester; hold high until ack
// req_addr   in   N_REQ*ADDR_W  byte address, requester i at [i*ADDR_W +: ADDR_W]
// req_op     in   N_REQ*2       00 read, 01 byte st, 10 half st, 11 word st
// req_wdata  in   N_REQ*32      store data, LSB-aligned (byte in [7:0], half in [15:0])
// ack        out  N_REQ         one-cycle completion pulse, at most one bit set
// err        out  1             valid with ack: 1 = misaligned, no RAM access done
// rdata      out  32            word read, valid with ack when op was 00, else 0
// ram_addr   out  ADDR_W        to RAM port address
// ram_cs     out  1             to RAM port chip select
// ram_op     out  2             to RAM port op
// ram_wdata  out  32           to RAM port write data
// ram_rdata  in   32            from RAM port; combinational, valid while cs & op==00
// BEHAVIOUR
// - FSM: IDLE -> ACCESS -> RESP -> IDLE. ERR path: IDLE -> RESP, skipping ACCESS.
// - IDLE: if any req is high, the arbiter picks winner w round-robin. Search starts
//   at ptr and wraps modulo N_REQ. It latches addr/op/wdata of w and checks alignment:
//   half with addr[0]=1 is misaligned; word with addr[1:0]!=0 is misaligned.
//   Misaligned -> set err_q=1 and go to RESP. Otherwise go to ACCESS.
//   ptr <= (w+1)%N_REQ on every grant, including error grants.
// - ACCESS: ram_cs=1, ram_addr/op/wdata come from the latch. At the closing edge,
//   the RAM commits the store and rdata_q <= ram_rdata if op==00, else 0.
// - RESP: ack[w]=1, err=err_q, rdata=rdata_q for this one cycle. Then IDLE.
// - Requester rule: drop req at the edge where ack is seen. The next IDLE samples
//   req one edge later, so a request is never issued twice.
// - Latency: req high before edge E0 -> ack high in the cycle after E0+1
//   (3 cycles from grant to IDLE). Error: ack in the cycle after E0.
// - Outside ACCESS: ram_cs=0, ram_op=00, ram_addr/ram_wdata=0. Outside RESP: ack=0,
//   err=0, rdata=0.
// - Changes to req_* while the arbiter is not in IDLE are ignored (latched copy used).
// - Reset: state=IDLE, ptr=0, ack=0, err=0, rdata=0, latches=0. ram_cs is gated
//   combinationally by !rst, so a store in ACCESS during a reset cycle does not
//   commit.
// - Simultaneous req: only the round-robin winner is served. Losers keep req high
//   and are served on later passes. Worst case wait = (N_REQ-1)*3 cycles.
// - The other RAM port (instruction fetch) is not controlled here. A same-word
//   read/write collision across ports follows the RAM's own behaviour.
// STRUCTURE
// - mem_pkg: MEM_OP_READ=2'b00, MEM_OP_SB=2'b01, MEM_OP_SH=2'b10, MEM_OP_SW=2'b11;
//   state enum {ARB_IDLE, ARB_ACCESS, ARB_RESP}; function is_misaligned(op, a[1:0]).
// - Sub-module rr_pick: comb, inputs req[N_REQ-1:0] and ptr, outputs any and
//   winner idx. Reused by the future bus arbiter.
// TESTING
// - Single SW req0 addr 0x0010 data 0xDEADBEEF, then read 0x0010 -> ack[0] after
//   3 cycles each, rdata=0xDEADBEEF, err=0.
// - SB req1 addr 0x0013 data 0xAA over word 0x11223344 at 0x0010; read back ->
//   0xAA223344.
// - SH addr 0x0001 -> ack with err=1 one cycle later, ram_cs never high. SW addr
//   0x0006 -> err=1. SH addr 0x0002 -> err=0.
// - req0 and req1 both held continuously, ptr=0 -> grants alternate 0,1,0,1.
//   No ack is ever 2'b11. Each requester is acked every 6 cycles.
// - rst asserted in the ACCESS cycle of SW 0x0020 data 0x12345678 -> no ack; word
//   at 0x0020 unchanged; all outputs 0 the next cycle.
// - Requester drops req at ack and its req_addr changes during ACCESS -> exactly one
//   transaction, at the originally latched address.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-port definitions: op encodings, arbiter states and the alignment rule
// used by every requester-facing block on the RAM port.
package mem_pkg;

  localparam logic [1:0] MEM_OP_READ = 2'b00;
  localparam logic [1:0] MEM_OP_SB   = 2'b01;
  localparam logic [1:0] MEM_OP_SH   = 2'b10;
  localparam logic [1:0] MEM_OP_SW   = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RESP
  } arb_state_e;

  function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] a);
    return ((op == MEM_OP_SH) && a[0]) || ((op == MEM_OP_SW) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping
// modulo N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] winner
);

  int unsigned idx;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(ptr) + i) % N_REQ;
      if (!any && req[idx[IDX_W-1:0]]) begin
        any    = 1'b1;
        winner = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among N_REQ requesters; one latched
// transaction at a time, misaligned stores answered with err and no RAM access.
module ram_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*2-1:0]      req_op,
  input  logic [N_REQ*32-1:0]     req_wdata,
  output logic [N_REQ-1:0]        ack,
  output logic                    err,
  output logic [31:0]             rdata,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic                    ram_cs,
  output logic [1:0]              ram_op,
  output logic [31:0]             ram_wdata,
  input  logic [31:0]             ram_rdata
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  arb_state_e         state_q;
  logic [IDX_W-1:0]   ptr_q, win_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [1:0]         op_q;
  logic [31:0]        wdata_q, rdata_q;
  logic               err_q;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx, ptr_next;
  logic [ADDR_W-1:0]  sel_addr;
  logic [1:0]         sel_op;
  logic [31:0]        sel_wdata;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .winner (pick_idx)
  );

  always_comb begin
    sel_addr  = req_addr[pick_idx*ADDR_W +: ADDR_W];
    sel_op    = req_op[pick_idx*2 +: 2];
    sel_wdata = req_wdata[pick_idx*32 +: 32];
    ptr_next  = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      addr_q  <= '0;
      op_q    <= MEM_OP_READ;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            win_q   <= pick_idx;
            ptr_q   <= ptr_next;
            addr_q  <= sel_addr;
            op_q    <= sel_op;
            wdata_q <= sel_wdata;
            // Cleared here so an error response never shows a stale read word.
            rdata_q <= '0;
            if (is_misaligned(sel_op, sel_addr[1:0])) begin
              err_q   <= 1'b1;
              state_q <= ARB_RESP;
            end else begin
              err_q   <= 1'b0;
              state_q <= ARB_ACCESS;
            end
          end
        end
        ARB_ACCESS: begin
          rdata_q <= (op_q == MEM_OP_READ) ? ram_rdata : '0;
          state_q <= ARB_RESP;
        end
        ARB_RESP: state_q <= ARB_IDLE;
        default:  state_q <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    ack       = '0;
    err       = 1'b0;
    rdata     = '0;
    ram_addr  = '0;
    ram_op    = MEM_OP_READ;
    ram_wdata = '0;
    if (state_q == ARB_RESP) begin
      ack[win_q] = 1'b1;
      err        = err_q;
      rdata      = rdata_q;
    end
    if (state_q == ARB_ACCESS) begin
      ram_addr  = addr_q;
      ram_op    = op_q;
      ram_wdata = wdata_q;
    end
  end

  // A store caught by reset in its ACCESS cycle must not commit.
  assign ram_cs = (state_q == ARB_ACCESS) && !rst;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural byte-write RAM on the port, scoreboard of
// expected responses checked whenever an ack appears.
module tb_ram_port_arbiter;
  import mem_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N*2-1:0]  req_op;
  logic [N*32-1:0] req_wdata;
  logic [N-1:0]    ack;
  logic            err;
  logic [31:0]     rdata;
  logic [AW-1:0]   ram_addr;
  logic            ram_cs;
  logic [1:0]      ram_op;
  logic [31:0]     ram_wdata;
  logic [31:0]     ram_rdata;

  ram_port_arbiter #(
    .N_REQ  (N),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_op    (req_op),
    .req_wdata (req_wdata),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_cs    (ram_cs),
    .ram_op    (ram_op),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, byte-lane write at the clock edge.
  logic [31:0] mem [0:(1<<(AW-2))-1];
  assign ram_rdata = mem[ram_addr[AW-1:2]];

  always @(posedge clk) begin
    if (ram_cs) begin
      case (ram_op)
        MEM_OP_SB: mem[ram_addr[AW-1:2]][8*int'(ram_addr[1:0]) +: 8] <= ram_wdata[7:0];
        MEM_OP_SH: mem[ram_addr[AW-1:2]][16*int'(ram_addr[1]) +: 16] <= ram_wdata[15:0];
        MEM_OP_SW: mem[ram_addr[AW-1:2]] <= ram_wdata;
        default: ;
      endcase
    end
  end

  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] rdata;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int nacks    = 0;
  int cs_count = 0;
  int cyc      = 0;
  int last_ack [N];
  logic track_int = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Response monitor and scoreboard consumer.
  always @(negedge clk) begin
    sb_entry_t e;
    if (ram_cs) cs_count++;
    if (!rst && ack != '0) begin
      nacks++;
      check("ack_onehot", 64'($countones(ack)), 64'd1);
      if (sb_q.size() == 0) begin
        check("unexpected_ack", 64'(ack), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("ack_idx", 64'(ack), 64'(1 << e.idx));
        check("ack_err", 64'(err), 64'(e.err));
        check("ack_rdata", 64'(rdata), 64'(e.rdata));
      end
      for (int i = 0; i < N; i++) begin
        if (ack[i] && track_int) begin
          if (last_ack[i] >= 0) check("ack_interval", 64'(cyc - last_ack[i]), 64'd6);
          last_ack[i] = cyc;
        end
      end
    end else if (!rst) begin
      check("quiet_outside_resp", {31'd0, err, rdata}, 64'd0);
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"}, 64'(ack), 64'd0);
    check({tag, "_err_rdata"}, {31'd0, err, rdata}, 64'd0);
    check({tag, "_ram_ctl"}, 64'({ram_cs, ram_op, ram_addr}), 64'd0);
    check({tag, "_ram_wdata"}, 64'(ram_wdata), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive(input int idx, input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [31:0] wd);
    req_addr[idx*AW +: AW] = a;
    req_op[idx*2 +: 2]     = op;
    req_wdata[idx*32 +: 32] = wd;
  endtask

  // Called one unit after a rising edge; returns one unit after the edge that ends RESP.
  task automatic do_txn(input int idx, input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                        input int e_lat);
    sb_entry_t e;
    int n0, cnt;
    e.idx = idx; e.err = e_err; e.rdata = e_rd;
    sb_q.push_back(e);
    drive(idx, op, a, wd);
    req[idx] = 1'b1;
    n0 = nacks;
    cnt = 0;
    while (nacks == n0 && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    req[idx] = 1'b0;
    check("latency", 64'(cnt), 64'(e_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs0, n0, cnt;
    sb_entry_t e;
    rst = 1'b1; req = '0; req_addr = '0; req_op = '0; req_wdata = '0;
    for (int i = 0; i < (1 << (AW - 2)); i++) mem[i] = '0;
    for (int i = 0; i < N; i++) last_ack[i] = -1;
    do_reset();
    check_outputs_zero("reset");

    // Word store and read back.
    do_txn(0, MEM_OP_SW, 15'h0010, 32'hDEADBEEF, 1'b0, 32'h0, 3);
    do_txn(0, MEM_OP_READ, 15'h0010, 32'h0, 1'b0, 32'hDEADBEEF, 3);

    // Byte store into lane 3.
    mem[4] = 32'h11223344;
    do_txn(1, MEM_OP_SB, 15'h0013, 32'h000000AA, 1'b0, 32'h0, 3);
    do_txn(1, MEM_OP_READ, 15'h0010, 32'h0, 1'b0, 32'hAA223344, 3);

    // Alignment rules.
    cs0 = cs_count;
    do_txn(0, MEM_OP_SH, 15'h0001, 32'h0000BEEF, 1'b1, 32'h0, 2);
    check("sh_mis_no_cs", 64'(cs_count - cs0), 64'd0);
    do_txn(1, MEM_OP_SW, 15'h0006, 32'hCAFECAFE, 1'b1, 32'h0, 2);
    check("sw_mis_no_cs", 64'(cs_count - cs0), 64'd0);
    check("mis_mem_untouched", 64'(mem[1]), 64'd0);
    mem[0] = 32'h0;
    do_txn(0, MEM_OP_SH, 15'h0002, 32'h00005566, 1'b0, 32'h0, 3);
    do_txn(0, MEM_OP_READ, 15'h0000, 32'h0, 1'b0, 32'h55660000, 3);

    // Both requesters held: strict alternation starting at requester 0.
    do_reset();
    mem[4] = 32'h0A0A0A0A;
    mem[5] = 32'h0B0B0B0B;
    for (int k = 0; k < 4; k++) begin
      e.idx = k % 2; e.err = 1'b0; e.rdata = (k % 2 == 0) ? 32'h0A0A0A0A : 32'h0B0B0B0B;
      sb_q.push_back(e);
    end
    drive(0, MEM_OP_READ, 15'h0010, 32'h0);
    drive(1, MEM_OP_READ, 15'h0014, 32'h0);
    track_int = 1'b1;
    n0 = nacks;
    req = 2'b11;
    cnt = 0;
    while (nacks < n0 + 4 && cnt < 40) begin
      @(posedge clk); #1; cnt++;
    end
    req = 2'b00;
    track_int = 1'b0;
    check("alternation_acks", 64'(nacks - n0), 64'd4);

    // Reset during the ACCESS cycle of a word store.
    mem[8] = 32'hCAFEF00D;
    n0 = nacks;
    drive(0, MEM_OP_SW, 15'h0020, 32'h12345678);
    req[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_gates_cs", 64'(ram_cs), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req[0] = 1'b0;
    check_outputs_zero("after_rst");
    check("rst_store_blocked", 64'(mem[8]), 64'hCAFEF00D);
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_ack", 64'(nacks - n0), 64'd0);

    // Address changes during ACCESS are ignored; a single transaction results.
    mem[12] = 32'h0;
    mem[13] = 32'h0;
    cs0 = cs_count;
    n0 = nacks;
    e.idx = 0; e.err = 1'b0; e.rdata = 32'h0;
    sb_q.push_back(e);
    drive(0, MEM_OP_SW, 15'h0030, 32'h55AA55AA);
    req[0] = 1'b1;
    @(posedge clk); #1;
    drive(0, MEM_OP_SW, 15'h0034, 32'hFFFFFFFF);
    cnt = 1;
    while (nacks == n0 && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    req[0] = 1'b0;
    check("latched_latency", 64'(cnt), 64'd3);
    repeat (6) @(posedge clk);
    #1;
    check("latched_word", 64'(mem[12]), 64'h55AA55AA);
    check("changed_addr_untouched", 64'(mem[13]), 64'd0);
    check("single_access", 64'(cs_count - cs0), 64'd1);
    check("single_ack", 64'(nacks - n0), 64'd1);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
